// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with hazard unit. Captures decoded
//                operands/controls from decode, forwards results from EX/MEM
//                and MEM/WB onto the EX operands, and stalls decode on
//                load-use (or, without forwarding, on any pending RAW).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters : DW (datapath width), AW (register address width),
//               CW (ALU control width)
//  Build macro: FORWARDING_EN - when defined, EX/MEM and MEM/WB results are
//               forwarded onto d1/d2/store data. When undefined, operands come
//               straight from the captured regfile values and decode is
//               stalled until the producer reaches MEM/WB.
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    id_*                     decoded instruction from the decode stage
//    flush                    kill the instruction entering EX
//    exmem_*, memwb_*         producer info from downstream pipeline regs
//    stall                    combinational decode/PC hold request
//    ex_valid                 EX slot holds a real instruction
//    d1_out/d2_out/imm_out    operands to the execution ALU
//    aluctrl_out              ALU op to the execution ALU
//    ex_dst, ex_reg_write,
//    ex_mem_read, ex_mem_write registered destination and controls
//    ex_store_data            forwarded rt value for stores
// ============================================================================
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_dst_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [CW-1:0] id_aluctrl,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_dst,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_dst,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] d1_out,
    output logic [DW-1:0] d2_out,
    output logic [DW-1:0] imm_out,
    output logic [CW-1:0] aluctrl_out,
    output logic [AW-1:0] ex_dst,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic [DW-1:0] ex_store_data
);

    // Shift opcodes take their operand from the shamt field, not the immediate
    localparam logic [CW-1:0] c_ALU_SLL = CW'(13);
    localparam logic [CW-1:0] c_ALU_SRL = CW'(14);
    localparam logic [CW-1:0] c_ALU_SRA = CW'(15);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic          r_ex_valid;
    logic [AW-1:0] r_rs_addr;
    logic [AW-1:0] r_rt_addr;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic [CW-1:0] r_aluctrl;
    logic          r_alu_src;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;

    logic          w_is_shift;
    logic [DW-1:0] w_imm_sel;
    logic          w_ex_match;
    logic          w_load_use;
    logic          w_raw_stall;
    logic          w_hazard;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    assign w_is_shift = (id_aluctrl == c_ALU_SLL) || (id_aluctrl == c_ALU_SRL) ||
                        (id_aluctrl == c_ALU_SRA);
    assign w_imm_sel  = w_is_shift ? {{(DW-5){1'b0}}, id_shamt} : id_imm;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // Instruction in EX targets a register that decode is reading
    assign w_ex_match = r_ex_valid && (r_dst != '0) &&
                        ((r_dst == id_rs_addr) || (r_dst == id_rt_addr));
    // A load's data is not available until MEM/WB, so one bubble is needed
    assign w_load_use = id_valid && w_ex_match && r_mem_read;

`ifdef FORWARDING_EN
    assign w_raw_stall = 1'b0;

    // EX/MEM is the younger producer and therefore wins over MEM/WB
    function automatic logic [DW-1:0] f_forward(input logic [AW-1:0] addr,
                                                input logic [DW-1:0] captured);
        logic [DW-1:0] v;
        v = captured;
        if ((addr != '0) && exmem_reg_write && (exmem_dst == addr)) begin
            v = exmem_result;
        end else if ((addr != '0) && memwb_reg_write && (memwb_dst == addr)) begin
            v = memwb_result;
        end
        return v;
    endfunction

    always_comb begin
        w_fwd_rs = f_forward(r_rs_addr, r_rs_data);
        w_fwd_rt = f_forward(r_rt_addr, r_rt_data);
    end
`else
    logic w_exmem_match;
    logic w_unused_fwd;

    // Without forwarding, decode waits until the producer is in MEM/WB;
    // the regfile writes before it reads, so MEM/WB needs no stall.
    assign w_exmem_match = exmem_reg_write && (exmem_dst != '0) &&
                           ((exmem_dst == id_rs_addr) || (exmem_dst == id_rt_addr));
    assign w_raw_stall   = id_valid && ((w_ex_match && r_reg_write) || w_exmem_match);

    always_comb begin
        w_fwd_rs = r_rs_data;
        w_fwd_rt = r_rt_data;
    end

    assign w_unused_fwd = ^{exmem_result, memwb_reg_write, memwb_dst, memwb_result};
`endif

    assign w_hazard = w_load_use || w_raw_stall;
    assign stall    = w_hazard && !rst && !flush;

    // ------------------------------------------------------------------
    // ID/EX register: rst > flush > stall bubble > capture.
    // Bubbles clear only the valid bit and controls; data simply holds.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_dst       <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_aluctrl   <= '0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush || stall || !id_valid) begin
            r_ex_valid  <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_ex_valid  <= 1'b1;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_dst       <= id_dst_addr;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= w_imm_sel;
            r_aluctrl   <= id_aluctrl;
            r_alu_src   <= id_alu_src;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Outputs to execution
    // ------------------------------------------------------------------
    assign ex_valid      = r_ex_valid;
    assign d1_out        = w_fwd_rs;
    assign d2_out        = r_alu_src ? r_imm : w_fwd_rt;
    assign imm_out       = r_imm;
    assign aluctrl_out   = r_aluctrl;
    assign ex_dst        = r_dst;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_store_data = w_fwd_rt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. A reference model of
//                the EX slot predicts stall and EX outputs each cycle and
//                pushes them to queues; a monitor pops and compares.
//                Handles both FORWARDING_EN builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_aluctrl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_result;
    logic        stall, ex_valid;
    logic [31:0] d1_out, d2_out, imm_out, ex_store_data;
    logic [4:0]  aluctrl_out, ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_stage #(.DW(32), .AW(5), .CW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_aluctrl(id_aluctrl), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .d1_out(d1_out), .d2_out(d2_out),
        .imm_out(imm_out), .aluctrl_out(aluctrl_out), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  ctl;
        logic        src, rw, mr, mw;
    } slot_t;

    typedef struct packed {
        logic [31:0] d1, d2, imm, sd;
        logic [4:0]  ctl, dst;
        logic        rw, mr, mw;
    } exp_t;

    slot_t m_ex;
    logic  m_stall;
    exp_t  eq[$];
    logic  sq[$];
    exp_t  mon_e;
    logic  mon_en;
    int    n_chk;
    int    n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value an instruction in EX should see for a source register
    function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] cap);
`ifdef FORWARDING_EN
        if (a != 0 && exmem_reg_write && exmem_dst == a) return exmem_result;
        if (a != 0 && memwb_reg_write && memwb_dst == a) return memwb_result;
`endif
        return cap;
    endfunction

    function automatic logic model_stall();
        logic reads_ex;
        if (rst || flush || !id_valid) return 1'b0;
        reads_ex = m_ex.valid && m_ex.dst != 0 &&
                   (m_ex.dst == id_rs_addr || m_ex.dst == id_rt_addr);
        if (reads_ex && m_ex.mr) return 1'b1;
`ifndef FORWARDING_EN
        if (reads_ex && m_ex.rw) return 1'b1;
        if (exmem_reg_write && exmem_dst != 0 &&
            (exmem_dst == id_rs_addr || exmem_dst == id_rt_addr)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Called once inputs for the cycle are settled: queue expectations
    task automatic apply();
        exp_t e;
        logic [31:0] rtv;
        m_stall = model_stall();
        sq.push_back(m_stall);
        if (m_ex.valid) begin
            rtv   = src_val(m_ex.rt, m_ex.rtd);
            e.d1  = src_val(m_ex.rs, m_ex.rsd);
            e.d2  = m_ex.src ? m_ex.imm : rtv;
            e.sd  = rtv;
            e.imm = m_ex.imm;
            e.ctl = m_ex.ctl;
            e.dst = m_ex.dst;
            e.rw  = m_ex.rw;
            e.mr  = m_ex.mr;
            e.mw  = m_ex.mw;
            eq.push_back(e);
        end
    endtask

    // Clock edge: move the modelled instruction from ID into EX
    task automatic advance();
        @(posedge clk);
        if (rst || flush || m_stall || !id_valid) begin
            m_ex.valid = 1'b0;
        end else begin
            m_ex.valid = 1'b1;
            m_ex.rs    = id_rs_addr;
            m_ex.rt    = id_rt_addr;
            m_ex.dst   = id_dst_addr;
            m_ex.rsd   = id_rs_data;
            m_ex.rtd   = id_rt_data;
            m_ex.imm   = (id_aluctrl >= 5'd13 && id_aluctrl <= 5'd15) ? {27'd0, id_shamt} : id_imm;
            m_ex.ctl   = id_aluctrl;
            m_ex.src   = id_alu_src;
            m_ex.rw    = id_reg_write;
            m_ex.mr    = id_mem_read;
            m_ex.mw    = id_mem_write;
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] ctl,
                          input logic src, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_dst_addr = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_aluctrl = ctl; id_alu_src = src; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fw(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                          input logic ww, input logic [4:0] wd, input logic [31:0] wr);
        exmem_reg_write = ew; exmem_dst = ed; exmem_result = er;
        memwb_reg_write = ww; memwb_dst = wd; memwb_result = wr;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_fw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        flush = 1'b0;
    endtask

    task automatic rand_inputs();
        set_id(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 5'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        set_fw(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (sq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL stall_queue: got empty queue expected an entry");
            end else begin
                chk("stall", 32'(stall), 32'(sq.pop_front()));
            end
            if (ex_valid) begin
                if (eq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL ex_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    mon_e = eq.pop_front();
                    chk("d1_out", d1_out, mon_e.d1);
                    chk("d2_out", d2_out, mon_e.d2);
                    chk("imm_out", imm_out, mon_e.imm);
                    chk("store_data", ex_store_data, mon_e.sd);
                    chk("aluctrl_out", 32'(aluctrl_out), 32'(mon_e.ctl));
                    chk("ex_dst", 32'(ex_dst), 32'(mon_e.dst));
                    chk("ex_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}),
                        32'({mon_e.rw, mon_e.mr, mon_e.mw}));
                end
            end else begin
                chk("bubble_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_chk = 0; n_err = 0; mon_en = 1'b0;
        m_ex = '0; m_stall = 1'b0;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Reset held with active stimulus: everything reads zero
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            rst = 1'b1;
            apply();
            @(negedge clk);
            chk("rst_ctl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall}), 32'd0);
            chk("rst_d1", d1_out, 32'd0);
            chk("rst_d2", d2_out, 32'd0);
            chk("rst_addr", 32'({aluctrl_out, ex_dst}), 32'd0);
            chk("rst_imm_sd", imm_out | ex_store_data, 32'd0);
            advance();
        end

        // First capture after reset release appears one cycle later
        rst = 1'b0; idle();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); @(negedge clk); chk("first_cap_pre", 32'(ex_valid), 32'd0); advance();
        idle(); apply(); @(negedge clk); chk("first_cap", 32'(ex_valid), 32'd1); advance();
        idle(); apply(); advance();

        // add r3,r1,r2 ; sub r4,r3,r1
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); advance();
        set_id(1'b1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); @(negedge clk);
`ifdef FORWARDING_EN
        chk("raw_alu_stall", 32'(stall), 32'd0); advance();
        idle(); set_fw(1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0);
        apply(); @(negedge clk); chk("raw_alu_d1", d1_out, 32'd12); advance();
`else
        chk("raw_alu_stall1", 32'(stall), 32'd1); advance();
        set_fw(1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0);
        apply(); @(negedge clk); chk("raw_alu_stall2", 32'(stall), 32'd1); advance();
        set_id(1'b1, 5'd3, 5'd1, 5'd4, 32'd12, 32'd5, 32'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fw(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd12);
        apply(); @(negedge clk); chk("raw_alu_stall3", 32'(stall), 32'd0); advance();
        idle(); apply(); @(negedge clk); chk("raw_alu_d1", d1_out, 32'd12); advance();
`endif

        // EX/MEM beats MEM/WB; r0 is never forwarded
        idle();
        set_id(1'b1, 5'd3, 5'd0, 5'd6, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); advance();
        idle(); set_fw(1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 32'd9);
        apply(); @(negedge clk);
`ifdef FORWARDING_EN
        chk("fwd_priority", d1_out, 32'd7);
`else
        chk("fwd_priority", d1_out, 32'd1);
`endif
        advance();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'hABC, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); advance();
        idle(); set_fw(1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9);
        apply(); @(negedge clk); chk("r0_no_fwd", d1_out, 32'hABC); advance();

        // lw r2 ; add r5,r2,r2
        idle();
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'd0, 32'd4, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(); advance();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); @(negedge clk); chk("lu_stall", 32'(stall), 32'd1); advance();
        set_fw(1'b1, 5'd2, 32'h104, 1'b0, 5'd0, 32'd0);
        apply(); @(negedge clk); chk("lu_bubble", 32'(ex_valid), 32'd0);
`ifdef FORWARDING_EN
        chk("lu_stall_drop", 32'(stall), 32'd0); advance();
        idle(); set_fw(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hDEAD);
        apply(); @(negedge clk);
`else
        chk("lu_stall_2", 32'(stall), 32'd1); advance();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 32'hDEAD, 32'hDEAD, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fw(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hDEAD);
        apply(); @(negedge clk); chk("lu_stall_drop", 32'(stall), 32'd0); advance();
        idle(); apply(); @(negedge clk);
`endif
        chk("lu_valid", 32'(ex_valid), 32'd1);
        chk("lu_d1", d1_out, 32'hDEAD);
        chk("lu_d2", d2_out, 32'hDEAD);
        advance();

        // Flush in the same cycle as a load-use stall
        idle();
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'd0, 32'd4, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(); advance();
        set_id(1'b1, 5'd2, 5'd2, 5'd5, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        apply(); @(negedge clk); chk("flush_stall", 32'(stall), 32'd0); advance();
        idle();
        set_id(1'b1, 5'd7, 5'd8, 5'd9, 32'd11, 32'd22, 32'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(); @(negedge clk);
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        chk("flush_stall_next", 32'(stall), 32'd0);
        advance();
        idle(); apply(); @(negedge clk); chk("flush_no_double", 32'(ex_valid), 32'd1); advance();

        // srl uses shamt, not the sign-extended immediate
        idle();
        set_id(1'b1, 5'd0, 5'd4, 5'd9, 32'd0, 32'h80, 32'hFFFF0004, 5'd4, 5'b01110,
               1'b1, 1'b1, 1'b0, 1'b0);
        apply(); advance();
        idle(); apply(); @(negedge clk);
        chk("shift_imm", imm_out, 32'h4);
        chk("shift_d2", d2_out, 32'h4);
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 39) == 0);
            apply();
            advance();
        end
        rst = 1'b0; idle(); apply(); advance();

        chk("exp_queue_drained", 32'(eq.size()), 32'd0);
        chk("stall_queue_drained", 32'(sq.size()), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
